// File: rtl/div_pkg.sv
// Shared types and helpers for the divide/multiply result stages.
// Provides the controller state type and modulo-2^N magnitude/negation helpers.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    // Two's-complement negate when en is set; wraps modulo 2^DIV_WIDTH.
    function automatic logic [DIV_WIDTH-1:0] cneg(input logic [DIV_WIDTH-1:0] x,
                                                   input logic                 en);
        return en ? (~x + 1'b1) : x;
    endfunction

    // Magnitude of a signed operand; raw pass-through when sgn is clear.
    function automatic logic [DIV_WIDTH-1:0] mag(input logic [DIV_WIDTH-1:0] x,
                                                  input logic                 sgn);
        return cneg(x, sgn & x[DIV_WIDTH-1]);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Sign correction of the unsigned divider result for signed division.
// Quotient takes the XOR of operand signs, remainder takes the dividend sign.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] div_z_i,
    input  logic               neg_q_i,
    input  logic               neg_r_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    assign lo_o = cneg(div_z_i[WIDTH-1:0], neg_q_i);
    assign hi_o = cneg(div_z_i[2*WIDTH-1:WIDTH], neg_r_i);

endmodule

// File: rtl/div_hilo_ctrl.sv
// Multicycle controller around the external combinational divider: registers
// operand magnitudes, waits SETTLE_CYCLES, then writes sign-corrected HI/LO.
module div_hilo_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH         = DIV_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [WIDTH-1:0]   div_a,
    output logic [WIDTH-1:0]   div_b,
    input  logic [2*WIDTH-1:0] div_z,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .div_z_i (div_z),
        .neg_q_i (neg_quo_q),
        .neg_r_i (neg_rem_q),
        .hi_o    (fix_hi),
        .lo_o    (fix_lo)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_a_q   <= '0;
            div_b_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_a_q   <= div_a_d;
            div_b_q   <= div_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_a_d   = div_a_q;
        div_b_d   = div_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed & dividend[WIDTH-1];
                    dbz_d     = 1'b0;
                    // Divide-by-zero is answered here; the divider never sees it.
                    if (divisor == '0) begin
                        hi_d   = dividend;
                        lo_d   = '1;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        div_a_d = mag(dividend, is_signed);
                        div_b_d = mag(divisor, is_signed);
                        cnt_d   = CW'(SETTLE_CYCLES);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == WAIT);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign div_a       = div_a_q;
    assign div_b       = div_b_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Bench for div_hilo_ctrl with a behavioural divider on div_a/div_b/div_z.
module tb_div_hilo_ctrl;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [63:0] div_z;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    always #5 clk = ~clk;

    always_comb begin
        if (div_b != 32'd0) div_z = {div_a % div_b, div_a / div_b};
        else                div_z = '0;
    end

    div_hilo_ctrl #(.WIDTH(32), .SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .div_a       (div_a),
        .div_b       (div_b),
        .div_z       (div_z),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] ma;
        logic [31:0] mb;
        logic        dbz;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: truncating signed/unsigned division done in 64-bit arithmetic.
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] elo, output logic [31:0] ehi,
                         output logic [31:0] ema, output logic [31:0] emb,
                         output logic edbz);
        longint sa, sb, q, r, m;
        sa = s ? longint'($signed(a)) : longint'({32'h0, a});
        sb = s ? longint'($signed(b)) : longint'({32'h0, b});
        if (b == 32'd0) begin
            elo = '1; ehi = a; edbz = 1'b1; ema = last_a; emb = last_b;
        end else begin
            q = sa / sb;
            r = sa % sb;
            elo = q[31:0];
            ehi = r[31:0];
            edbz = 1'b0;
            m = (sa < 0) ? -sa : sa;
            ema = m[31:0];
            m = (sb < 0) ? -sb : sb;
            emb = m[31:0];
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; is_signed = $urandom_range(0, 1);
        dividend = $urandom; divisor = $urandom;
    endtask

    task automatic wait_done(input int cyc0, input logic edbz, input logic [31:0] elo,
                             input logic [31:0] ehi, input logic [31:0] ema,
                             input logic [31:0] emb, input string nm);
        int cyc = cyc0;
        int nb = 0;
        int lat;
        chk({nm, "_flag_early"}, 64'(div_by_zero), 64'(edbz));
        while (!done && cyc < 20) begin
            if (busy) nb++;
            @(negedge clk);
            cyc++;
        end
        lat = edbz ? 0 : SETTLE;
        if (!done) begin
            chk({nm, "_timeout"}, 64'(done), 64'd1);
        end else begin
            chk({nm, "_latency"}, 64'(cyc), 64'(lat));
            chk({nm, "_busycnt"}, 64'(nb), 64'(edbz ? 0 : SETTLE - cyc0));
            chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
            chk({nm, "_lo"}, 64'(lo), 64'(elo));
            chk({nm, "_hi"}, 64'(hi), 64'(ehi));
            chk({nm, "_flag"}, 64'(div_by_zero), 64'(edbz));
            chk({nm, "_div_a"}, 64'(div_a), 64'(ema));
            chk({nm, "_div_b"}, 64'(div_b), 64'(emb));
        end
        if (!edbz) begin
            last_a = ema;
            last_b = emb;
        end
    endtask

    initial begin
        logic [31:0] elo, ehi, ema, emb, ra, rb;
        logic edbz, rs;
        int dn;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          32'd100,        32'd7,   1'b0};
        tbl[1] = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   32'd100,        32'd7,   1'b0};
        tbl[2] = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          32'd100,        32'd7,   1'b0};
        tbl[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          32'h80000000,   32'd1,   1'b0};
        tbl[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   32'd1,   1'b0};
        tbl[5] = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          32'hFFFFFFFF,   32'd1,   1'b1};
        tbl[6] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   32'hFFFFFFFF,   32'd1,   1'b1};
        tbl[7] = '{1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          32'd7,          32'd100, 1'b0};

        clr_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_ab", {div_a, div_b}, 64'd0);
        chk("rst_ctl", 64'({busy, done, div_by_zero}), 64'd0);
        clr_n = 1'b1;
        @(negedge clk);

        // Each entry is issued on the done cycle of the previous one.
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].s, tbl[i].a, tbl[i].b);
            wait_done(0, tbl[i].dbz, tbl[i].lo, tbl[i].hi, tbl[i].ma, tbl[i].mb,
                      $sformatf("vec%0d", i));
        end

        // start while busy is dropped
        @(negedge clk);
        issue(1'b0, 32'd200, 32'd9);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, 1'b0, 32'd22, 32'd2, 32'd200, 32'd9, "busy_start");
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("busy_start_extra_done", 64'(dn), 64'd0);
        chk("busy_start_lo_hold", 64'(lo), 64'd22);

        // reset during WAIT aborts
        issue(1'b0, 32'd50, 32'd5);
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_ab", {div_a, div_b}, 64'd0);
        chk("midrst_ctl", 64'({busy, done, div_by_zero}), 64'd0);
        @(negedge clk);
        clr_n = 1'b1;
        last_a = '0; last_b = '0;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("midrst_no_done", 64'(dn), 64'd0);
        issue(1'b0, 32'd9, 32'd2);
        wait_done(0, 1'b0, 32'd4, 32'd1, 32'd9, 32'd2, "post_rst");

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: ra = 32'd0;
                1: ra = 32'h80000000;
                2: ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'd1;
                2: rb = 32'hFFFFFFFF;
                3: rb = $urandom_range(2, 15);
                4: rb = 32'hFFFFFFFF - $urandom_range(0, 15);
                default: rb = $urandom;
            endcase
            model(rs, ra, rb, elo, ehi, ema, emb, edbz);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            issue(rs, ra, rb);
            wait_done(0, edbz, elo, ehi, ema, emb, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
